// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit: funct3 codes,
// FSM state encoding and operand-signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
    localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return !op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_MULHSU) ||
               (op == MULDIV_OP_DIV)  || (op == MULDIV_OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MULDIV_OP_MULH) || (op == MULDIV_OP_DIV) ||
               (op == MULDIV_OP_REM);
    endfunction

    // REM/REMU: remainder sign follows the dividend only
    function automatic logic is_rem_op(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider, one quotient bit per cycle. Operands are
// magnitudes; sign fix-up is done by the caller.
module muldiv_div_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            clr_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic            done_o,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    localparam int CNT_W = $clog2(XLEN + 1);

    logic [XLEN-1:0]  quo_q, rem_q, dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active_q;
    logic [XLEN:0]    r_shift, diff;

    // quo_q doubles as the dividend shift register
    always_comb begin
        r_shift = {rem_q, quo_q[XLEN-1]};
        diff    = r_shift - {1'b0, dvs_q};
    end

    assign done_o      = active_q && (cnt_q == CNT_W'(XLEN));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else if (start_i) begin
            quo_q    <= dividend_i;
            rem_q    <= '0;
            dvs_q    <= divisor_i;
            cnt_q    <= '0;
            active_q <= 1'b1;
        end else if (clr_i) begin
            active_q <= 1'b0;
        end else if (active_q && !done_o) begin
            cnt_q <= cnt_q + 1'b1;
            if (!diff[XLEN]) begin
                rem_q <= diff[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_q <= r_shift[XLEN-1:0];
                quo_q <= {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle M-extension unit: shift-add multiplier with MUL_UNROLL bits per
// cycle, restoring divider, sign fix-up and valid/ready handshake FSM.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int MUL_UNROLL   = 1,
    parameter int DIV_FASTPATH = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);

    localparam int MUL_CYCLES = XLEN / MUL_UNROLL;
    localparam int CNT_W      = $clog2(MUL_CYCLES + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state_q, state_d;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   mcand_q, mplier_q, result_q;
    logic [2*XLEN-1:0] acc_q, acc_step, mul_full;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q, dz_q, fast_q;

    logic              accept, sa, sb, neg_d, b_zero, ovf, fast, mul_last;
    logic [XLEN-1:0]   a_mag, b_mag, mul_res, div_res, fast_res, rem_a;
    logic [XLEN-1:0]   quo_f, rem_f, quo_raw, rem_raw;
    logic [XLEN:0]     sum;
    logic              div_start, div_clr, div_done;

    assign ready_o  = (state_q == MD_IDLE);
    assign valid_o  = (state_q == MD_DONE);
    assign busy_o   = (state_q != MD_IDLE);
    assign result_o = result_q;

    assign accept = valid_i && ready_o && !flush_i;
    assign sa     = is_signed_a(op_i) && a_i[XLEN-1];
    assign sb     = is_signed_b(op_i) && b_i[XLEN-1];
    assign a_mag  = sa ? -a_i : a_i;
    assign b_mag  = sb ? -b_i : b_i;
    assign neg_d  = is_rem_op(op_i) ? sa : (sa ^ sb);
    assign b_zero = (b_i == '0);
    assign ovf    = !op_i[0] && (a_i == MOST_NEG) && (b_i == '1);
    assign fast   = (DIV_FASTPATH != 0) && !is_mul_op(op_i) && (b_zero || ovf);

    assign mul_last = (cnt_q == CNT_W'(MUL_CYCLES));

    // MUL_UNROLL shift-add steps per cycle on a right-shifting accumulator
    always_comb begin
        acc_step = acc_q;
        sum      = '0;
        for (int j = 0; j < MUL_UNROLL; j++) begin
            sum      = {1'b0, acc_step[2*XLEN-1:XLEN]} +
                       (mplier_q[j] ? {1'b0, mcand_q} : '0);
            acc_step = {sum, acc_step[XLEN-1:1]};
        end
    end

    always_comb begin
        mul_full = neg_q ? -acc_q : acc_q;
        mul_res  = (op_q == MULDIV_OP_MUL) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
        // divide-by-zero quotient stays all-ones regardless of sign flags
        quo_f    = dz_q ? '1 : (neg_q ? -quo_raw : quo_raw);
        rem_f    = neg_q ? -rem_raw : rem_raw;
        div_res  = op_q[1] ? rem_f : quo_f;
        rem_a    = neg_q ? -mcand_q : mcand_q;
        fast_res = dz_q ? (op_q[1] ? rem_a : '1) : (op_q[1] ? '0 : MOST_NEG);
    end

    assign div_start = accept && !is_mul_op(op_i) && !fast;
    assign div_clr   = flush_i || ((state_q == MD_DIV) && div_done);

    muldiv_div_core #(.XLEN(XLEN)) u_div_core (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (div_start),
        .clr_i       (div_clr),
        .dividend_i  (a_mag),
        .divisor_i   (b_mag),
        .done_o      (div_done),
        .quotient_o  (quo_raw),
        .remainder_o (rem_raw)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= MD_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (accept) state_d = is_mul_op(op_i) ? MD_MUL : MD_DIV;
            MD_MUL:  if (mul_last) state_d = MD_DONE;
            MD_DIV:  if (fast_q || div_done) state_d = MD_DONE;
            MD_DONE: if (ready_i) state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
        if (flush_i) state_d = MD_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            fast_q   <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= op_i;
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= neg_d;
            dz_q     <= b_zero;
            fast_q   <= fast;
        end else if (!flush_i) begin
            case (state_q)
                MD_MUL: begin
                    if (!mul_last) begin
                        acc_q    <= acc_step;
                        mplier_q <= mplier_q >> MUL_UNROLL;
                        cnt_q    <= cnt_q + 1'b1;
                    end else begin
                        result_q <= mul_res;
                    end
                end
                MD_DIV: begin
                    if (fast_q)        result_q <= fast_res;
                    else if (div_done) result_q <= div_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: three configurations (default, 4-bit
// unrolled multiplier, no divide fast path) driven one operation at a time.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  flush, vin, rdy_i;
    wire  [2:0]  rdy_o, vout, busy;
    logic [2:0]  op  [3];
    logic [31:0] a   [3];
    logic [31:0] b   [3];
    logic [31:0] res [3];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_UNROLL(1), .DIV_FASTPATH(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[0]), .valid_i(vin[0]),
        .ready_o(rdy_o[0]), .op_i(op[0]), .a_i(a[0]), .b_i(b[0]),
        .valid_o(vout[0]), .ready_i(rdy_i[0]), .result_o(res[0]), .busy_o(busy[0]));

    muldiv_unit #(.XLEN(32), .MUL_UNROLL(4), .DIV_FASTPATH(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[1]), .valid_i(vin[1]),
        .ready_o(rdy_o[1]), .op_i(op[1]), .a_i(a[1]), .b_i(b[1]),
        .valid_o(vout[1]), .ready_i(rdy_i[1]), .result_o(res[1]), .busy_o(busy[1]));

    muldiv_unit #(.XLEN(32), .MUL_UNROLL(1), .DIV_FASTPATH(0)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush[2]), .valid_i(vin[2]),
        .ready_o(rdy_o[2]), .op_i(op[2]), .a_i(a[2]), .b_i(b[2]),
        .valid_o(vout[2]), .ready_i(rdy_i[2]), .result_o(res[2]), .busy_o(busy[2]));

    typedef struct {
        int          inst;
        logic [31:0] val;
        int          lat;
        string       name;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    int         acc_cyc [3];
    logic [2:0] vprev    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: latency on valid rise, value and source on handshake
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vout[k] && !vprev[k]) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_valid: inst%0d result %h expected none", k, res[k]);
                end else begin
                    chk({sb_q[0].name, "_latency"}, 32'(cyc - acc_cyc[k]), 32'(sb_q[0].lat));
                end
            end
            if (vout[k] && rdy_i[k] && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_inst"}, 32'(k), 32'(mon_e.inst));
                chk(mon_e.name, res[k], mon_e.val);
            end
        end
        vprev = vout;
    end

    task automatic issue(input int k, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp, input int lat, input bit push, input string name);
        int   n = 0;
        exp_t t;
        @(posedge clk); #1;
        while (!rdy_o[k] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s: ready_o timeout got 0 expected 1", name);
            return;
        end
        op[k] = o; a[k] = x; b[k] = y; vin[k] = 1'b1;
        if (push) begin
            t.inst = k; t.val = exp; t.lat = lat; t.name = name;
            sb_q.push_back(t);
        end
        acc_cyc[k] = cyc + 1;
        @(posedge clk); #1;
        vin[k] = 1'b0; op[k] = MULDIV_OP_MULHU; a[k] = 32'hDEAD_BEEF; b[k] = 32'h1234_5678;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb_q.size() != 0 || rdy_o != 3'b111) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending %0d expected 0", sb_q.size());
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; vin = '0; flush = '0; rdy_i = '1;
        for (int k = 0; k < 3; k++) begin
            op[k] = '0; a[k] = '0; b[k] = '0; acc_cyc[k] = 0;
        end
        #12;
        chk("reset_ready", {29'd0, rdy_o}, 32'd7);
        chk("reset_valid", {29'd0, vout},  32'd0);
        chk("reset_busy",  {29'd0, busy},  32'd0);
        chk("reset_result", res[0], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        issue(0, MULDIV_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1, "mul_7x-3");
        issue(0, MULDIV_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1, "mulh_min");
        issue(0, MULDIV_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1, "mulhu_ones");
        issue(0, MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1, "mulhsu_ones");
        issue(0, MULDIV_OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, 1, "div_-7_2");
        issue(0, MULDIV_OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, 1, "rem_-7_2");
        issue(0, MULDIV_OP_REMU,   32'd100,      32'd7,        32'd2,         33, 1, "remu_100_7");
        issue(0, MULDIV_OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 1,  1, "div_by0_fast");
        issue(0, MULDIV_OP_REM,    32'd5,        32'd0,        32'd5,         1,  1, "rem_by0_fast");
        issue(0, MULDIV_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1, "div_ovf_fast");
        issue(0, MULDIV_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, 1, "rem_ovf_fast");
        issue(0, MULDIV_OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33, 1, "divu_noovf");
        wait_idle();

        issue(1, MULDIV_OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 9, 1, "u4_mul_7x-3");
        issue(1, MULDIV_OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 9, 1, "u4_mulh_min");
        issue(1, MULDIV_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 1, "u4_mulhsu");
        wait_idle();

        issue(2, MULDIV_OP_DIV,    32'd5,        32'd0,        32'hFFFF_FFFF, 33, 1, "slow_div_by0");
        issue(2, MULDIV_OP_REM,    32'd5,        32'd0,        32'd5,         33, 1, "slow_rem_by0");
        issue(2, MULDIV_OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1, "slow_div_ovf");
        issue(2, MULDIV_OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        33, 1, "slow_rem_ovf");
        issue(2, MULDIV_OP_DIV,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 33, 1, "slow_div_-5_0");
        issue(2, MULDIV_OP_REM,    32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 33, 1, "slow_rem_-5_0");
        wait_idle();

        // back-pressure: result held in DONE
        rdy_i[0] = 1'b0;
        issue(0, MULDIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1, "divu_100_7_bp");
        n = 0;
        while (!vout[0] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_valid_seen", {31'd0, vout[0]}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_hold", {31'd0, vout[0]}, 32'd1);
            chk("bp_result_hold", res[0], 32'd14);
            chk("bp_ready_low", {31'd0, rdy_o[0]}, 32'd0);
            @(posedge clk); #1;
        end
        rdy_i[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_ready_after", {31'd0, rdy_o[0]}, 32'd1);
        chk("bp_valid_after", {31'd0, vout[0]}, 32'd0);

        // flush five cycles into a divide
        issue(0, MULDIV_OP_DIV, 32'd1000, 32'd3, 32'd0, 0, 0, "div_flushed");
        repeat (4) @(posedge clk);
        #1 flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        chk("flush_ready", {31'd0, rdy_o[0]}, 32'd1);
        chk("flush_busy",  {31'd0, busy[0]},  32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (vout[0]) n++;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", 32'(n), 32'd0);

        // request presented together with flush is dropped
        op[0] = MULDIV_OP_MUL; a[0] = 32'd9; b[0] = 32'd9; vin[0] = 1'b1; flush[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0; flush[0] = 1'b0;
        chk("flush_req_dropped", {31'd0, busy[0]}, 32'd0);

        issue(0, MULDIV_OP_MUL, 32'd3, 32'd4, 32'd12, 33, 1, "mul_after_flush");
        wait_idle();

        // async reset in the middle of a multiply
        issue(0, MULDIV_OP_MUL, 32'd5, 32'd6, 32'd0, 0, 0, "mul_reset");
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready",  {31'd0, rdy_o[0]}, 32'd1);
        chk("arst_valid",  {31'd0, vout[0]},  32'd0);
        chk("arst_busy",   {31'd0, busy[0]},  32'd0);
        chk("arst_result", res[0], 32'd0);
        #3 rst_n = 1'b1;

        issue(0, MULDIV_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 33, 1, "mulhu_after_rst");
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RISC-V M-extension unit: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Successor to the single-cycle combinational multiply/divide datapath inside the core ALU. Frees the critical path and lets area trade against latency.
- Sits beside the ALU in EX. The core holds the instruction with valid/ready handshakes until the result returns.
- Supports flush, back-pressure and a fast path for RISC-V special-case divides.

Parameters:
- XLEN, 32, operand/result width; must be even, at least 8.
- MUL_UNROLL, 1, multiplier bits retired per cycle; must divide XLEN (1, 2, 4 or 8).
- DIV_FASTPATH, 1, when 1, divide-by-zero and signed overflow complete in 1 cycle; when 0, they take the full iterative latency and give identical values.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- flush_i  in  1  abort in-flight op; has priority over everything except reset.
- valid_i  in  1  request valid.
- ready_o  out  1  unit can accept a request.
- op_i  in  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- a_i  in  XLEN  rs1 operand.
- b_i  in  XLEN  rs2 operand.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts result.
- result_o  out  XLEN  result.
- busy_o  out  1  state is not IDLE (for hazard logic).

Behaviour:
- Reset (rst_ni low, async): state IDLE, ready_o=1, valid_o=0, busy_o=0, result_o=0, all counters and accumulators 0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&ready_o, latch op_i, a_i, b_i; operands are sampled only on that edge.
  - Signed ops (MULH a,b; MULHSU a only; DIV/REM both) convert operands to magnitudes and record the result-negate flag.
  - Negate flag: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Next state is MUL for op<4, else DIV.
  - DIV goes straight to DONE when DIV_FASTPATH=1 and b_i==0, or op is DIV/REM with a_i = most-negative and b_i = all-ones.
- MUL:
  - Shift-add over 2*XLEN accumulator, MUL_UNROLL multiplier bits per cycle, XLEN/MUL_UNROLL cycles, then DONE.
  - The final stage applies two's-complement negate across the full 2*XLEN bits when flagged.
  - Selects bits [XLEN-1:0] for MUL, [2XLEN-1:XLEN] otherwise.
- DIV:
  - Restoring divide, 1 quotient bit per cycle, XLEN cycles, then DONE.
  - Quotient and remainder are negated per the flags in the final stage.
- Special divide values (both paths):
  - Divide by zero: quotient all-ones, remainder = original a_i.
  - Signed overflow: quotient = most-negative, remainder 0.
- DONE:
  - valid_o=1; result_o is held stable while ready_i=0.
  - On ready_i: valid_o falls next cycle, state IDLE.
  - ready_o is 0 here; no back-to-back overlap.
- Latency: request accepted on edge T; valid_o rises after edge T+N.
  - MUL-class ops: N = XLEN/MUL_UNROLL + 1.
  - DIV-class ops: N = XLEN + 1.
  - Fast path: N = 1.
- flush_i=1 in any state forces IDLE at the next edge, with valid_o=0.
  - A request presented with flush_i is not accepted.
  - flush_i in DONE discards the result even if ready_i=1.
- ready_o=0 and busy_o=1 in MUL, DIV and DONE.
- op_i, a_i and b_i changes outside the accept edge are ignored.
- An async reset mid-operation returns the unit to IDLE immediately with outputs at reset values.

Decomposition:
- Shared package/defs holds:
  - MULDIV_OP_* funct3 constants.
  - State encoding MD_IDLE/MD_MUL/MD_DIV/MD_DONE.
  - Helpers is_mul_op, is_signed_a, is_signed_b.
- One natural sub-module: muldiv_div_core. This is the restoring divider: start/done, dividend/divisor in, quotient/remainder out.
- Multiplier iteration, sign fix-up and FSM stay in the top.

Test Plan (XLEN=32, MUL_UNROLL=1 unless stated):
- MUL a=7 b=0xFFFFFFFD -> result 0xFFFFFFEB; valid_o 33 cycles after accept. Same with MUL_UNROLL=4 -> 9 cycles.
- High products:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Signed and unsigned divide:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - Each valid_o 33 cycles after accept.
- Special cases, 1-cycle with fast path:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
  - With DIV_FASTPATH=0: same values at 33 cycles.
- Back-pressure: hold ready_i=0 for 10 cycles in DONE -> valid_o and result_o stable, ready_o=0. Raise ready_i -> ready_o=1 next cycle.
- Flush and reset:
  - flush_i pulse 5 cycles into DIV -> no valid_o; ready_o=1 next cycle; following MUL 3*4 -> 12.
  - rst_ni low mid-MUL -> outputs at reset values immediately.
